// File: rtl/stage_led_view.sv
// Front-panel LED/buzzer view: blink divider, stage LEDs,
// run-colour counter, set/power indicators and finish beeper.
module stage_led_view #(
  parameter int STAGES      = 8,
  parameter int HALF_PERIOD = 25000000,
  parameter int BEEP_PULSES = 3,
  parameter int COLOR_W     = 3
) (
  input  logic                      cp,
  input  logic                      rst,
  input  logic [2:0]                state,
  input  logic [STAGES-1:0]         stage_mask,
  input  logic [$clog2(STAGES)-1:0] active_stage,
  input  logic                      click,
  input  logic                      power_in,
  input  logic                      set_in,
  output logic [STAGES-1:0]         stage_led,
  output logic                      beep,
  output logic                      power_led,
  output logic                      set_led,
  output logic [COLOR_W-1:0]        color_led,
  output logic                      blink
);

  localparam int AW = $clog2(STAGES);
  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    M_OFF    = 3'd0,
    M_BEGIN  = 3'd1,
    M_SET    = 3'd2,
    M_RUN    = 3'd3,
    M_ERROR  = 3'd4,
    M_PAUSE  = 3'd5,
    M_FINISH = 3'd6,
    M_SPARE  = 3'd7
  } mstate_e;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_ON   = 2'd1,
    B_OFF  = 2'd2
  } bseq_e;

  mstate_e mst;
  assign mst = mstate_e'(state);

  logic [CW-1:0]      div_q, div_d;
  logic               blink_q, blink_d;
  logic               wrap;
  logic [STAGES-1:0]  led_q, led_d;
  logic [STAGES-1:0]  run_pat;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               set_q, set_d;
  logic               pwr_q, pwr_d;
  bseq_e              bs_q, bs_d;
  logic [3:0]         pulse_q, pulse_d;
  logic [CW-1:0]      bcnt_q, bcnt_d;
  logic               fin_q, fin_d;
  logic               fin_now;
  logic               entry;

  assign wrap = (div_q == HP_LAST);

  always_comb begin
    div_d   = wrap ? '0 : div_q + 1'b1;
    blink_d = blink_q ^ wrap;
  end

  // An out-of-range active_stage matches no bit, so nothing blinks.
  always_comb begin
    run_pat = stage_mask;
    for (int i = 0; i < STAGES; i++) begin
      if (active_stage == AW'(i)) run_pat[i] = blink_q;
    end
  end

  always_comb begin
    led_d = stage_mask;
    set_d = set_in;
    case (mst)
      M_OFF, M_SPARE: begin
        led_d = '0;
        set_d = 1'b0;
      end
      M_BEGIN, M_FINISH: begin
        led_d = '1;
        set_d = 1'b1;
      end
      M_RUN:   led_d = run_pat;
      default: led_d = stage_mask;
    endcase
  end

  // Colour advances on the blink 0->1 edge, only while running.
  always_comb begin
    color_d = '0;
    if (mst == M_RUN) begin
      color_d = (wrap && !blink_q) ? color_q + 1'b1 : color_q;
    end
    pwr_d = power_in;
  end

  assign fin_now = (mst == M_FINISH);
  assign entry   = fin_now && !fin_q;
  assign fin_d   = fin_now;

  always_comb begin
    bs_d    = bs_q;
    pulse_d = pulse_q;
    bcnt_d  = bcnt_q;
    if (!fin_now) begin
      bs_d    = B_IDLE;
      pulse_d = '0;
      bcnt_d  = '0;
    end else if (entry) begin
      bs_d    = B_ON;
      pulse_d = 4'(BEEP_PULSES);
      bcnt_d  = '0;
    end else begin
      case (bs_q)
        B_ON: begin
          if (bcnt_q == HP_LAST) begin
            bs_d   = B_OFF;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        B_OFF: begin
          if (bcnt_q == HP_LAST) begin
            bcnt_d  = '0;
            pulse_d = pulse_q - 1'b1;
            bs_d    = (pulse_q == 4'd1) ? B_IDLE : B_ON;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        default: begin
          bs_d   = B_IDLE;
          bcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      blink_q <= 1'b0;
      led_q   <= '0;
      color_q <= '0;
      set_q   <= 1'b0;
      pwr_q   <= 1'b0;
      bs_q    <= B_IDLE;
      pulse_q <= '0;
      bcnt_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      color_q <= color_d;
      set_q   <= set_d;
      pwr_q   <= pwr_d;
      bs_q    <= bs_d;
      pulse_q <= pulse_d;
      bcnt_q  <= bcnt_d;
      fin_q   <= fin_d;
    end
  end

  assign stage_led = led_q;
  assign color_led = color_q;
  assign set_led   = set_q;
  assign power_led = pwr_q;
  assign blink     = blink_q;
  assign beep      = (bs_q == B_ON) || click;

endmodule

// File: tb/tb_stage_led_view.sv
// Randomized bench for stage_led_view against a time-based model,
// with an 8-stage and a 6-stage instance sharing stimulus.
module tb_stage_led_view;

  localparam int HP = 4;
  localparam int BP = 3;

  logic       cp = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic [7:0] mask8;
  logic [2:0] act8;
  logic [2:0] act6;
  logic       click;
  logic       pwr;
  logic       setin;

  logic [7:0] led8;
  logic [5:0] led6;
  logic       beep8, beep6;
  logic       pow8, pow6;
  logic       set8, set6;
  logic [2:0] col8, col6;
  logic       blink8, blink6;

  int checks = 0;
  int failures = 0;

  int          n;
  logic [15:0] exp8, exp6;
  logic [2:0]  ecolor;
  logic        eset, epow;
  bit          fin_prev, bact;
  int          bstart;

  always #5 cp = ~cp;

  stage_led_view #(
    .STAGES(8), .HALF_PERIOD(HP), .BEEP_PULSES(BP), .COLOR_W(3)
  ) dut8 (
    .cp(cp), .rst(rst), .state(state),
    .stage_mask(mask8), .active_stage(act8),
    .click(click), .power_in(pwr), .set_in(setin),
    .stage_led(led8), .beep(beep8),
    .power_led(pow8), .set_led(set8),
    .color_led(col8), .blink(blink8)
  );

  stage_led_view #(
    .STAGES(6), .HALF_PERIOD(HP), .BEEP_PULSES(BP), .COLOR_W(3)
  ) dut6 (
    .cp(cp), .rst(rst), .state(state),
    .stage_mask(mask8[5:0]), .active_stage(act6),
    .click(click), .power_in(pwr), .set_in(setin),
    .stage_led(led6), .beep(beep6),
    .power_led(pow6), .set_led(set6),
    .color_led(col6), .blink(blink6)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_stage(input logic [2:0] st,
                                            input logic [15:0] m,
                                            input int act,
                                            input bit bl,
                                            input int ns);
    logic [15:0] ones;
    logic [15:0] r;
    ones = 16'((1 << ns) - 1);
    r = m & ones;
    case (st)
      3'd0, 3'd7: r = '0;
      3'd1, 3'd6: r = ones;
      3'd3: if (act < ns) r[act] = bl;
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    n = 0; exp8 = '0; exp6 = '0; ecolor = '0;
    eset = 1'b0; epow = 1'b0;
    fin_prev = 1'b0; bact = 1'b0; bstart = 0;
  endtask

  // Divider and blink are pure functions of edges since reset.
  task automatic model_edge();
    bit blb;
    blb = ((n / HP) % 2) == 1;
    n++;
    exp8 = exp_stage(state, {8'h0, mask8}, int'(act8), blb, 8);
    exp6 = exp_stage(state, {10'h0, mask8[5:0]}, int'(act6), blb, 6);
    if (state == 3'd3) begin
      if (n % (2 * HP) == HP) ecolor = ecolor + 3'd1;
    end else begin
      ecolor = '0;
    end
    if (state == 3'd1 || state == 3'd6) eset = 1'b1;
    else if (state == 3'd0 || state == 3'd7) eset = 1'b0;
    else eset = setin;
    epow = pwr;
    if (state == 3'd6 && !fin_prev) begin
      bact = 1'b1;
      bstart = n;
    end else if (state != 3'd6) begin
      bact = 1'b0;
    end else if (bact && (n - bstart) >= 2 * HP * BP) begin
      bact = 1'b0;
    end
    fin_prev = (state == 3'd6);
  endtask

  task automatic check_all();
    logic eb, ebeep;
    eb = ((n / HP) % 2) == 1;
    ebeep = click | (bact && (((n - bstart) / HP) % 2 == 0));
    check("blink8", 32'(blink8), 32'(eb));
    check("blink6", 32'(blink6), 32'(eb));
    check("stage8", 32'(led8), 32'(exp8[7:0]));
    check("stage6", 32'(led6), 32'(exp6[5:0]));
    check("color", 32'(col8), 32'(ecolor));
    check("set_led", 32'(set8), 32'(eset));
    check("power_led", 32'(pow8), 32'(epow));
    check("beep8", 32'(beep8), 32'(ebeep));
    check("beep6", 32'(beep6), 32'(ebeep));
  endtask

  task automatic cyc();
    @(posedge cp);
    #1;
    model_edge();
    check_all();
  endtask

  // Reset lands between edges; outputs must clear without a clock.
  task automatic areset(input bit c);
    #2;
    rst = 1'b1;
    click = c;
    #1;
    model_reset();
    check_all();
    @(posedge cp);
    #1;
    check_all();
    rst = 1'b0;
    click = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; state = '0; mask8 = '0; act8 = '0; act6 = '0;
    click = 1'b0; pwr = 1'b0; setin = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge cp);
      #1;
      check_all();
    end
    rst = 1'b0;

    state = 3'd3; mask8 = 8'h0F; act8 = 3'd2; act6 = 3'd7;
    pwr = 1'b1; setin = 1'b1;
    repeat (70) cyc();

    state = 3'd6;
    repeat (30) cyc();

    state = 3'd3; cyc();
    state = 3'd6; repeat (10) cyc();
    state = 3'd5; cyc();
    state = 3'd6; repeat (30) cyc();

    state = 3'd3;
    guard = 0;
    while (ecolor != 3'd5 && guard < 200) begin
      cyc();
      guard++;
    end
    check("color_reach5", 32'(col8), 32'd5);
    state = 3'd5; cyc();
    state = 3'd0; cyc();

    state = 3'd3; repeat (5) cyc();
    areset(1'b1);
    repeat (3) cyc();

    state = 3'd6; repeat (6) cyc();
    areset(1'b0);
    repeat (30) cyc();

    repeat (3000) begin
      if ($urandom_range(0, 11) == 0) state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) mask8 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) act8 = 3'($urandom);
      if ($urandom_range(0, 7) == 0) act6 = 3'($urandom);
      click = ($urandom_range(0, 9) == 0);
      pwr = 1'($urandom);
      setin = 1'($urandom);
      if ($urandom_range(0, 199) == 0) areset(1'($urandom));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_led_view.md
STAGE_LED_VIEW -- requirements
Module: stage_led_view

Interface
REQ-001 SHALL have parameter STAGES, default 8, number of programme-stage LEDs (2..16).
REQ-002 SHALL have parameter HALF_PERIOD, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 SHALL have parameter BEEP_PULSES, default 3, number of buzzer pulses on entry to finish (1..15).
REQ-004 SHALL have parameter COLOR_W, default 3, width of the run-colour counter.
REQ-005 cp  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 state  input  3  machine state: 0 shutdown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish; 7 is treated as shutdown.
REQ-008 stage_mask  input  STAGES  selected-stage pattern from the controller.
REQ-009 active_stage  input  clog2(STAGES)  index of the stage currently executing.
REQ-010 click  input  1  key-press indication.
REQ-011 power_in, set_in  input  1 each  power and set flags from the controller.
REQ-012 stage_led  output  STAGES  stage LEDs, registered.
REQ-013 beep  output  1  buzzer drive.
REQ-014 power_led, set_led  output  1 each  power and set indicators, registered.
REQ-015 color_led  output  COLOR_W  run-colour indicator, registered.
REQ-016 blink  output  1  internal blink phase.

Function
REQ-017 SHALL contain a divider counting 0..HALF_PERIOD-1 that wraps to 0; blink SHALL toggle on every wrap cycle; it runs in every state.
REQ-018 stage_led SHALL update one cycle after its inputs: shutdown -> all 0; begin or finish -> all 1; run -> stage_mask with bit active_stage replaced by blink; pause, set, error -> stage_mask.
REQ-019 In run, if active_stage >= STAGES, no bit SHALL blink and stage_led SHALL equal stage_mask.
REQ-020 color_led SHALL increment modulo 2^COLOR_W on each cycle where blink goes 0->1 while state is run, and SHALL clear to 0 on the next cycle after any non-run state is sampled.
REQ-021 set_led SHALL be 1 in begin and finish, 0 in shutdown, otherwise set_in; power_led SHALL equal set_in... power_in, registered one cycle.
REQ-022 Beep sequencer SHALL have states IDLE, ON, OFF with a pulse counter of 4 bits and its own half-period counter.
REQ-023 Entry to finish, meaning state==6 sampled after a cycle with state!=6, SHALL load the pulse counter with BEEP_PULSES, clear the half-period counter and go to ON.
REQ-024 ON SHALL last HALF_PERIOD cycles, then go to OFF; OFF SHALL last HALF_PERIOD cycles, then decrement the pulse counter and go to ON if the result is nonzero, else to IDLE.
REQ-025 Leaving finish in any sequencer state SHALL return the sequencer to IDLE on the next cycle.
REQ-026 Staying in finish after IDLE is reached SHALL NOT restart the sequence; re-entry SHALL restart it.
REQ-027 beep SHALL be (sequencer in ON) OR click, with click acting combinationally in every state including shutdown.

Reset
REQ-028 While rst is high, SHALL force: divider=0, blink=0, stage_led=0, color_led=0, power_led=0, set_led=0, sequencer IDLE, pulse counter 0; beep then equals click.
REQ-029 Reset mid-beep or mid-run SHALL abort the sequence; after rst falls, a finish state already present SHALL count as a new entry.

Verification (HALF_PERIOD=4, STAGES=8, BEEP_PULSES=3)
REQ-030 Run sequence: state=3, stage_mask=8'h0F, active_stage=2 -> stage_led bit2 toggles every 4 cycles, other bits =0x0B pattern, color_led increments every 8 cycles and wraps 7->0.
REQ-031 Finish entry: state 3->6 -> stage_led=8'hFF next cycle; beep high 4, low 4, three times (24 cycles), then 0 while state stays 6.
REQ-032 Abort: leave finish during the second ON pulse -> beep 0 the next cycle; re-enter -> full 3 pulses again.
REQ-033 Out-of-range stage: active_stage=9 with STAGES=8... use STAGES=6 and active_stage=7 in run -> stage_led==stage_mask and no toggling.
REQ-034 Async reset: assert rst between edges during run -> outputs 0 immediately, without a clock edge; click=1 during reset -> beep=1.
REQ-035 Non-run states: state 5 with color_led=5 -> color_led=0 next cycle, stage_led=stage_mask; state 0 -> stage_led=0, set_led=0.
